// File: rtl/reg_serializer.sv
// Parallel-to-serial stage: captures one word on load&&ready and shifts it out
// one bit per accepted beat under valid/ready handshake on both sides.
module reg_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    output logic             ready,
    output logic             sout,
    output logic             svalid,
    input  logic             sready,
    output logic             last
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic             ready_nxt;
    logic             svalid_nxt;
    logic             sout_nxt;
    logic             last_nxt;

    // Next-state, datapath and next-output logic; outputs are registered below
    always_comb begin
        state_nxt  = state;
        shreg_nxt  = shreg;
        count_nxt  = count;
        ready_nxt  = 1'b0;
        svalid_nxt = 1'b0;
        sout_nxt   = 1'b0;
        last_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (load) begin
                    shreg_nxt = in;
                    count_nxt = CW'(WIDTH - 1);
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (sready) begin
                    if (count != '0) begin
                        shreg_nxt = LSB_FIRST ? (shreg >> 1) : (shreg << 1);
                        count_nxt = count - CW'(1);
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Outputs reflect the state being entered, so they line up with it
        ready_nxt  = (state_nxt == IDLE);
        svalid_nxt = (state_nxt == SHIFT);
        if (state_nxt == SHIFT) begin
            sout_nxt = LSB_FIRST ? shreg_nxt[0] : shreg_nxt[WIDTH-1];
            last_nxt = (count_nxt == '0);
        end
    end

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            shreg  <= '0;
            count  <= '0;
            ready  <= 1'b1;
            svalid <= 1'b0;
            sout   <= 1'b0;
            last   <= 1'b0;
        end else begin
            state  <= state_nxt;
            shreg  <= shreg_nxt;
            count  <= count_nxt;
            ready  <= ready_nxt;
            svalid <= svalid_nxt;
            sout   <= sout_nxt;
            last   <= last_nxt;
        end
    end

endmodule

// File: tb/tb_reg_serializer.sv
// Directed bench for reg_serializer: LSB-first and MSB-first instances share
// stimulus and are checked against hand-computed bit streams.
module tb_reg_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in;
    logic       load;
    logic       sready;

    logic ready_l, sout_l, svalid_l, last_l;
    logic ready_m, sout_m, svalid_m, last_m;

    int n_vec = 0;
    int n_err = 0;
    int sv_cycles = 0;

    always #5 clk = ~clk;

    reg_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .rst(rst), .in(in), .load(load), .ready(ready_l),
        .sout(sout_l), .svalid(svalid_l), .sready(sready), .last(last_l)
    );

    reg_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .rst(rst), .in(in), .load(load), .ready(ready_m),
        .sout(sout_m), .svalid(svalid_m), .sready(sready), .last(last_m)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
    task automatic tick();
        if (svalid_l) sv_cycles++;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready_l"},  32'(ready_l),  32'd1);
        check({tag, "_svalid_l"}, 32'(svalid_l), 32'd0);
        check({tag, "_sout_l"},   32'(sout_l),   32'd0);
        check({tag, "_last_l"},   32'(last_l),   32'd0);
        check({tag, "_ready_m"},  32'(ready_m),  32'd1);
        check({tag, "_svalid_m"}, 32'(svalid_m), 32'd0);
    endtask

    task automatic check_beat(input string tag, input logic el, input logic em, input logic elast);
        check({tag, "_sout_l"},   32'(sout_l),   32'(el));
        check({tag, "_sout_m"},   32'(sout_m),   32'(em));
        check({tag, "_last_l"},   32'(last_l),   32'(elast));
        check({tag, "_last_m"},   32'(last_m),   32'(elast));
        check({tag, "_svalid_l"}, 32'(svalid_l), 32'd1);
        check({tag, "_ready_l"},  32'(ready_l),  32'd0);
    endtask

    // Send one word; s_lsb/s_msb bit i is the expected sout on beat i.
    // Before accepting beat stall_at, hold sready low for stall_len cycles.
    task automatic send_word(input string tag, input logic [7:0] w,
                             input logic [7:0] s_lsb, input logic [7:0] s_msb,
                             input int stall_at, input int stall_len,
                             input int exp_sv);
        check({tag, "_ready_pre"}, 32'(ready_l), 32'd1);
        sv_cycles = 0;
        in = w; load = 1'b1; sready = 1'b1;
        tick();
        load = 1'b0;
        in = ~w;
        for (int i = 0; i < 8; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    sready = 1'b0;
                    check_beat({tag, "_stall"}, s_lsb[i], s_msb[i], 1'b0);
                    tick();
                end
                sready = 1'b1;
            end
            check_beat($sformatf("%s_b%0d", tag, i), s_lsb[i], s_msb[i], i == 7);
            tick();
        end
        check_idle({tag, "_done"});
        check({tag, "_svcycles"}, 32'(sv_cycles), 32'(exp_sv));
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; sready = 1'b1; in = 8'h00;

        // Reset held two cycles
        tick(); tick();
        rst = 1'b0;
        check_idle("reset");
        tick();
        check_idle("idle_noload");

        // A5: LSB stream 1,0,1,0,0,1,0,1 ; MSB stream identical
        send_word("a5", 8'hA5, 8'hA5, 8'hA5, 99, 0, 8);
        // 81: both streams 1,0,0,0,0,0,0,1
        send_word("81", 8'h81, 8'h81, 8'h81, 99, 0, 8);
        // C2: LSB stream 0,1,0,0,0,0,1,1 ; MSB stream 1,1,0,0,0,0,1,0
        send_word("c2", 8'hC2, 8'hC2, 8'h43, 99, 0, 8);
        // 3C with a 3-cycle stall before beat 2: 11 SHIFT cycles
        send_word("3c", 8'h3C, 8'h3C, 8'h3C, 2, 3, 11);

        // Load held high: FF then 00, one IDLE bubble between words
        in = 8'hFF; load = 1'b1; sready = 1'b1;
        tick();
        in = 8'h00;
        for (int i = 0; i < 8; i++) begin
            check_beat($sformatf("ff_b%0d", i), 1'b1, 1'b1, i == 7);
            tick();
        end
        check_idle("bubble");
        tick();
        in = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            check_beat($sformatf("00_b%0d", i), 1'b0, 1'b0, i == 7);
            tick();
        end
        load = 1'b0;
        check_idle("b2b_done");
        tick();

        // Reset after beat 4 of F0 discards the word
        in = 8'hF0; load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_beat($sformatf("f0_b%0d", i), 1'b0, 1'b1, 1'b0);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("mid_rst");
        // 0F: LSB stream 1,1,1,1,0,0,0,0 ; MSB stream 0,0,0,0,1,1,1,1
        send_word("0f", 8'h0F, 8'h0F, 8'hF0, 99, 0, 8);

        // Reset wins over a simultaneous load
        in = 8'h55; load = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; load = 1'b0;
        check_idle("rst_load");
        tick();
        check_idle("rst_load_after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
